// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg: shared types, mode constants and the port-index width helper for
// mem_port_arbiter.   Rev 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
// ============================================================================
// rr_priority_encoder: picks the first requester at or after start_ptr,
// wrapping past the top index.   Rev 1.0
// ============================================================================
`default_nettype none

module rr_priority_encoder
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [port_idx_w(NUM_PORTS)-1:0] start_ptr,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [port_idx_w(NUM_PORTS)-1:0] idx,
  output logic                             valid
);

  localparam int IW = port_idx_w(NUM_PORTS);

  logic [IW:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      // one extra bit holds start_ptr + offset before the modulo wrap
      pos = {1'b0, start_ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(NUM_PORTS)) pos = pos - (IW+1)'(NUM_PORTS);
      if (!valid && req[pos[IW-1:0]]) begin
        valid          = 1'b1;
        idx            = pos[IW-1:0];
        gnt[pos[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: N-master arbiter onto a single-outstanding memory port,
// round-robin or fixed priority.   Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_read,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_byte_enable,
  output logic [NUM_PORTS-1:0]              req_resp,
  output logic [DATA_WIDTH-1:0]             req_rdata,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [DATA_WIDTH/8-1:0]           mem_byte_enable,
  input  logic                              mem_resp,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int IW   = port_idx_w(NUM_PORTS);
  localparam int BE_W = DATA_WIDTH / 8;

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [BE_W-1:0]       be_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]    = req_byte_enable[g*BE_W +: BE_W];
  end

  logic [NUM_PORTS-1:0] enc_gnt;
  logic [IW-1:0]        enc_idx;
  logic                 enc_valid;
  logic [IW-1:0]        start_ptr;

  assign start_ptr = (RR_MODE == ARB_MODE_RR) ? rr_ptr_q : '0;

  rr_priority_encoder #(
    .NUM_PORTS (NUM_PORTS)
  ) u_enc (
    .req       (req_read | req_write),
    .start_ptr (start_ptr),
    .gnt       (enc_gnt),
    .idx       (enc_idx),
    .valid     (enc_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d     = BUSY;
          grant_d     = enc_gnt;
          // a port raising both strobes gets a write
          mem_write_d = req_write[enc_idx];
          mem_read_d  = req_read[enc_idx] & ~req_write[enc_idx];
          addr_d      = addr_arr[enc_idx];
          wdata_d     = wdata_arr[enc_idx];
          be_d        = be_arr[enc_idx];
          if (RR_MODE == ARB_MODE_RR) begin
            rr_ptr_d = (enc_idx == IW'(NUM_PORTS-1)) ? '0 : enc_idx + IW'(1);
          end
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  logic resp_fire;
  assign resp_fire       = (state_q == BUSY) && mem_resp;
  assign req_resp        = resp_fire ? grant_q : '0;
  assign req_rdata       = resp_fire ? mem_rdata : '0;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (!(|(req_read & req_write)));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed and randomized transaction checks of
// mem_port_arbiter against a transaction-level model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_read, req_write;
  logic [NP*AW-1:0] req_address;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*BW-1:0] req_byte_enable;
  logic             mem_resp;
  logic [DW-1:0]    mem_rdata;

  logic [NP-1:0] rr_req_resp, fx_req_resp;
  logic [DW-1:0] rr_req_rdata, fx_req_rdata;
  logic          rr_mem_read, fx_mem_read, rr_mem_write, fx_mem_write;
  logic [AW-1:0] rr_mem_address, fx_mem_address;
  logic [DW-1:0] rr_mem_wdata, fx_mem_wdata;
  logic [BW-1:0] rr_mem_be, fx_mem_be;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .req_resp(rr_req_resp), .req_rdata(rr_req_rdata), .mem_read(rr_mem_read),
    .mem_write(rr_mem_write), .mem_address(rr_mem_address), .mem_wdata(rr_mem_wdata),
    .mem_byte_enable(rr_mem_be), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata), .req_byte_enable(req_byte_enable),
    .req_resp(fx_req_resp), .req_rdata(fx_req_rdata), .mem_read(fx_mem_read),
    .mem_write(fx_mem_write), .mem_address(fx_mem_address), .mem_wdata(fx_mem_wdata),
    .mem_byte_enable(fx_mem_be), .mem_resp(mem_resp), .mem_rdata(mem_rdata));

  // observed outputs of whichever instance the current test targets
  bit            use_fx = 1'b0;
  logic [NP-1:0] o_resp;
  logic [DW-1:0] o_rdata, o_wdata;
  logic          o_read, o_write;
  logic [AW-1:0] o_addr;
  logic [BW-1:0] o_be;
  always_comb begin
    o_resp  = use_fx ? fx_req_resp    : rr_req_resp;
    o_rdata = use_fx ? fx_req_rdata   : rr_req_rdata;
    o_read  = use_fx ? fx_mem_read    : rr_mem_read;
    o_write = use_fx ? fx_mem_write   : rr_mem_write;
    o_addr  = use_fx ? fx_mem_address : rr_mem_address;
    o_wdata = use_fx ? fx_mem_wdata   : rr_mem_wdata;
    o_be    = use_fx ? fx_mem_be      : rr_mem_be;
  end

  int checks = 0;
  int failures = 0;

  // pending master transactions and the round-robin pointer of the model
  bit            p_valid [NP];
  bit            p_write [NP];
  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];
  logic [BW-1:0] p_be    [NP];
  int            m_ptr;

  task automatic drive_ports();
    for (int i = 0; i < NP; i++) begin
      req_read[i]                 = p_valid[i] && !p_write[i];
      req_write[i]                = p_valid[i] && p_write[i];
      req_address[i*AW +: AW]     = p_addr[i];
      req_wdata[i*DW +: DW]       = p_wdata[i];
      req_byte_enable[i*BW +: BW] = p_be[i];
    end
  endtask

  task automatic set_txn(input int p, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    p_valid[p] = 1'b1; p_write[p] = wr; p_addr[p] = a; p_wdata[p] = d; p_be[p] = be;
  endtask

  task automatic rand_txn(input int p);
    set_txn(p, 1'($urandom_range(0, 1)), $urandom, $urandom, BW'($urandom_range(0, 15)));
  endtask

  task automatic clear_ports();
    for (int i = 0; i < NP; i++) begin
      p_valid[i] = 1'b0; p_write[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_be[i] = '0;
    end
    drive_ports();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = '0;
    clear_ports();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  function automatic int model_winner();
    int start;
    start = use_fx ? 0 : m_ptr;
    for (int k = 0; k < NP; k++)
      if (p_valid[(start + k) % NP]) return (start + k) % NP;
    return -1;
  endfunction

  // One full transaction: called at a negedge with the DUT idle and the
  // pending requests already driven.
  task automatic run_txn(input string tag, input int lat, input logic [DW-1:0] rd,
                         output int w);
    logic [NP-1:0] exp_resp;
    w = model_winner();
    checks++;
    if (w < 0) begin
      failures++;
      $display("FAIL %s_setup: winner=%0d required a pending port", tag, w);
      return;
    end
    if (!use_fx) m_ptr = (w + 1) % NP;
    exp_resp = '0; exp_resp[w] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_read !== !p_write[w] || o_write !== p_write[w]) begin
      failures++;
      $display("FAIL %s_strobe: rd=%b wr=%b required rd=%b wr=%b (port %0d)",
               tag, o_read, o_write, !p_write[w], p_write[w], w);
    end
    checks++;
    if (o_addr !== p_addr[w] || o_wdata !== p_wdata[w] || o_be !== p_be[w]) begin
      failures++;
      $display("FAIL %s_fields: addr=%h wdata=%h be=%h required %h %h %h (port %0d)",
               tag, o_addr, o_wdata, o_be, p_addr[w], p_wdata[w], p_be[w], w);
    end
    repeat (lat) begin
      @(negedge clk);
      checks++;
      if (o_resp !== '0 || o_addr !== p_addr[w]) begin
        failures++;
        $display("FAIL %s_hold: resp=%b addr=%h required 0 and %h", tag, o_resp, o_addr, p_addr[w]);
      end
    end
    mem_resp = 1'b1; mem_rdata = rd;
    p_valid[w] = 1'b0;
    drive_ports();
    #1;
    checks++;
    if (o_resp !== exp_resp || o_rdata !== rd) begin
      failures++;
      $display("FAIL %s_resp: resp=%b rdata=%h required %b %h", tag, o_resp, o_rdata, exp_resp, rd);
    end
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if (o_resp !== '0 || o_rdata !== '0 || o_read !== 1'b0 || o_write !== 1'b0) begin
      failures++;
      $display("FAIL %s_after: resp=%b rdata=%h rd=%b wr=%b required all 0",
               tag, o_resp, o_rdata, o_read, o_write);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rr_mem_read, rr_mem_write, rr_mem_address, rr_mem_wdata, rr_mem_be, rr_req_resp, rr_req_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_rr: outputs=%h required 0",
               {rr_mem_read, rr_mem_write, rr_mem_address, rr_mem_wdata, rr_mem_be, rr_req_resp, rr_req_rdata});
    end
    checks++;
    if ({fx_mem_read, fx_mem_write, fx_mem_address, fx_mem_wdata, fx_mem_be, fx_req_resp, fx_req_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_fx: outputs=%h required 0",
               {fx_mem_read, fx_mem_write, fx_mem_address, fx_mem_wdata, fx_mem_be, fx_req_resp, fx_req_rdata});
    end
  endtask

  task automatic test_single_read();
    int w;
    do_reset();
    set_txn(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    drive_ports();
    run_txn("single_read", 3, 32'hDEAD_BEEF, w);
  endtask

  task automatic test_write_path();
    int w;
    do_reset();
    set_txn(0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    drive_ports();
    run_txn("write_path", 2, $urandom, w);
  endtask

  task automatic test_rr_fairness();
    int w;
    do_reset();
    for (int i = 0; i < NP; i++) rand_txn(i);
    drive_ports();
    for (int n = 0; n < 6; n++) begin
      run_txn($sformatf("rr_fair%0d", n), 0, $urandom, w);
      if (w >= 0) rand_txn(w);
      drive_ports();
    end
  endtask

  task automatic test_fixed_priority();
    int w;
    do_reset();
    rand_txn(0); rand_txn(1);
    drive_ports();
    for (int n = 0; n < 3; n++) begin
      run_txn($sformatf("fixed_p0_%0d", n), $urandom_range(0, 2), $urandom, w);
      if (n < 2) rand_txn(0);
      drive_ports();
    end
    run_txn("fixed_p1", 1, $urandom, w);
  endtask

  task automatic test_reset_mid_busy();
    int w;
    do_reset();
    set_txn(0, 1'b0, 32'hA0, 32'h0, 4'hF);
    drive_ports();
    run_txn("mid_pre", 0, $urandom, w);
    set_txn(1, 1'b0, 32'hB0, 32'h0, 4'hF);
    drive_ports();
    @(negedge clk);
    checks++;
    if (o_read !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_grant: mem_read=%b required 1", o_read);
    end
    rst = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({o_read, o_write, o_addr, o_wdata, o_be, o_resp, o_rdata} !== '0) begin
      failures++;
      $display("FAIL mid_busy_reset: outputs=%h required 0",
               {o_read, o_write, o_addr, o_wdata, o_be, o_resp, o_rdata});
    end
    @(negedge clk);
    rst = 1'b0; mem_resp = 1'b0; mem_rdata = '0; m_ptr = 0;
    clear_ports();
    set_txn(1, 1'b0, 32'hC0, 32'h0, 4'h3);
    set_txn(2, 1'b1, 32'hD0, 32'h55, 4'hC);
    drive_ports();
    run_txn("mid_post1", 1, $urandom, w);
    run_txn("mid_post2", 0, $urandom, w);
  endtask

  task automatic test_spurious_and_drop();
    logic [DW-1:0] rd;
    do_reset();
    mem_resp = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    checks++;
    if (o_resp !== '0 || o_rdata !== '0) begin
      failures++;
      $display("FAIL spurious_resp: resp=%b rdata=%h required 0", o_resp, o_rdata);
    end
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    #1;
    checks++;
    if (o_read !== 1'b0 || o_write !== 1'b0) begin
      failures++;
      $display("FAIL spurious_state: rd=%b wr=%b required 0", o_read, o_write);
    end
    set_txn(0, 1'b0, 32'h300, 32'h0, 4'hF);
    drive_ports();
    @(negedge clk);
    clear_ports();
    repeat (2) @(negedge clk);
    checks++;
    if (o_read !== 1'b1 || o_addr !== 32'h300) begin
      failures++;
      $display("FAIL drop_hold: rd=%b addr=%h required 1 and 300", o_read, o_addr);
    end
    rd = $urandom;
    mem_resp = 1'b1; mem_rdata = rd;
    #1;
    checks++;
    if (o_resp !== 3'b001 || o_rdata !== rd) begin
      failures++;
      $display("FAIL drop_resp: resp=%b rdata=%h required 001 %h", o_resp, o_rdata, rd);
    end
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
    repeat (2) begin
      #1;
      checks++;
      if (o_resp !== '0 || o_read !== 1'b0) begin
        failures++;
        $display("FAIL drop_after: resp=%b rd=%b required 0", o_resp, o_read);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random(input string tag, input int n_txn);
    int w;
    do_reset();
    for (int n = 0; n < n_txn; n++) begin
      for (int i = 0; i < NP; i++)
        if (!p_valid[i] && $urandom_range(0, 1) == 1) rand_txn(i);
      if (!(p_valid[0] || p_valid[1] || p_valid[2])) rand_txn($urandom_range(0, NP-1));
      drive_ports();
      run_txn($sformatf("%s%0d", tag, n), $urandom_range(0, 3), $urandom, w);
    end
  endtask

  initial begin
    use_fx = 1'b0;
    test_reset();
    test_single_read();
    test_write_path();
    test_rr_fairness();
    test_reset_mid_busy();
    test_spurious_and_drop();
    test_random("rand_rr", 40);
    use_fx = 1'b1;
    test_fixed_priority();
    test_random("rand_fx", 40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
